// File: rtl/iq_alu.sv
// ALU issue queue: compacting age-ordered entries, dual-slot enqueue, dual CDB wakeup,
// oldest-ready single issue over a valid/ready handshake.
module iq_alu #(
    parameter int DEPTH     = 8,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 128
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  logic                                enq_valid_i,
    output logic                                enq_ready_o,
    input  logic [1:0]                          enq_choose_i,
    input  logic [1:0][1:0][PREG_W-1:0]         enq_src_preg_i,
    input  logic [1:0][1:0][31:0]               enq_src_data_i,
    input  logic [1:0][1:0]                     enq_src_valid_i,
    input  logic [1:0][PAYLOAD_W-1:0]           enq_payload_i,
    input  logic [1:0]                          cdb_valid_i,
    input  logic [1:0][PREG_W-1:0]              cdb_preg_i,
    input  logic [1:0][31:0]                    cdb_data_i,
    output logic                                issue_valid_o,
    input  logic                                issue_ready_i,
    output logic [1:0][31:0]                    issue_src_data_o,
    output logic [PAYLOAD_W-1:0]                issue_payload_o,
    output logic [$clog2(DEPTH+1)-1:0]          count_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]                  valid_q, valid_d;
    logic [DEPTH-1:0][1:0][PREG_W-1:0] preg_q, preg_d;
    logic [DEPTH-1:0][1:0][31:0]       data_q, data_d;
    logic [DEPTH-1:0][1:0]             rdy_q, rdy_d;
    logic [DEPTH-1:0][PAYLOAD_W-1:0]   payload_q, payload_d;
    logic [CW-1:0]                     count_q, count_d;

    logic [DEPTH-1:0][1:0][31:0]       wk_data;
    logic [DEPTH-1:0][1:0]             wk_rdy;
    logic [1:0][1:0][31:0]             in_data;
    logic [1:0][1:0]                   in_rdy;

    logic                              sel_found;
    logic [IW-1:0]                     sel_idx;
    logic                              enq_fire;
    logic                              issue_fire;
    logic [CW-1:0]                     surv;
    logic [CW-1:0]                     pos1;

    // preg 0 is the hardwired zero register and never wakes anything
    function automatic logic cdb_hit(input logic v, input logic [PREG_W-1:0] cp,
                                     input logic [PREG_W-1:0] sp);
        return v && (cp != '0) && (cp == sp);
    endfunction

    assign enq_ready_o = rst_n && !flush_i && (count_q <= CW'(DEPTH-2));
    assign enq_fire    = enq_valid_i && enq_ready_o;
    assign count_o     = count_q;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (valid_q[i] && rdy_q[i][0] && rdy_q[i][1]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign issue_valid_o    = sel_found && rst_n && !flush_i;
    assign issue_fire       = issue_valid_o && issue_ready_i;
    assign issue_src_data_o = issue_valid_o ? data_q[sel_idx] : '0;
    assign issue_payload_o  = issue_valid_o ? payload_q[sel_idx] : '0;

    always_comb begin
        wk_data = data_q;
        wk_rdy  = rdy_q;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (!rdy_q[i][j]) begin
                    if (cdb_hit(cdb_valid_i[0], cdb_preg_i[0], preg_q[i][j])) begin
                        wk_rdy[i][j]  = 1'b1;
                        wk_data[i][j] = cdb_data_i[0];
                    end else if (cdb_hit(cdb_valid_i[1], cdb_preg_i[1], preg_q[i][j])) begin
                        wk_rdy[i][j]  = 1'b1;
                        wk_data[i][j] = cdb_data_i[1];
                    end
                end
            end
        end
    end

    always_comb begin
        in_data = enq_src_data_i;
        in_rdy  = enq_src_valid_i;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 2; j++) begin
                if (!enq_src_valid_i[k][j]) begin
                    if (cdb_hit(cdb_valid_i[0], cdb_preg_i[0], enq_src_preg_i[k][j])) begin
                        in_rdy[k][j]  = 1'b1;
                        in_data[k][j] = cdb_data_i[0];
                    end else if (cdb_hit(cdb_valid_i[1], cdb_preg_i[1], enq_src_preg_i[k][j])) begin
                        in_rdy[k][j]  = 1'b1;
                        in_data[k][j] = cdb_data_i[1];
                    end
                end
            end
        end
    end

    assign surv = count_q - CW'(issue_fire);
    assign pos1 = surv + CW'(enq_choose_i[0]);

    always_comb begin
        valid_d   = '0;
        preg_d    = '0;
        data_d    = '0;
        rdy_d     = '0;
        payload_d = '0;
        count_d   = surv;
        // compact: entries at or above the issued one move down a slot
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_fire && (IW'(i) >= sel_idx)) begin
                if (i < DEPTH-1) begin
                    valid_d[i]   = valid_q[i+1];
                    preg_d[i]    = preg_q[i+1];
                    data_d[i]    = wk_data[i+1];
                    rdy_d[i]     = wk_rdy[i+1];
                    payload_d[i] = payload_q[i+1];
                end
            end else begin
                valid_d[i]   = valid_q[i];
                preg_d[i]    = preg_q[i];
                data_d[i]    = wk_data[i];
                rdy_d[i]     = wk_rdy[i];
                payload_d[i] = payload_q[i];
            end
        end
        if (enq_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq_choose_i[0] && (CW'(i) == surv)) begin
                    valid_d[i]   = 1'b1;
                    preg_d[i]    = enq_src_preg_i[0];
                    data_d[i]    = in_data[0];
                    rdy_d[i]     = in_rdy[0];
                    payload_d[i] = enq_payload_i[0];
                end
                if (enq_choose_i[1] && (CW'(i) == pos1)) begin
                    valid_d[i]   = 1'b1;
                    preg_d[i]    = enq_src_preg_i[1];
                    data_d[i]    = in_data[1];
                    rdy_d[i]     = in_rdy[1];
                    payload_d[i] = enq_payload_i[1];
                end
            end
            count_d = pos1 + CW'(enq_choose_i[1]);
        end
        if (flush_i) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q   <= valid_d;
            count_q   <= count_d;
            preg_q    <= preg_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: tb/tb_iq_alu.sv
// Directed bench for iq_alu: dispatch, wakeup ordering, bypass, full/drain and flush.
module tb_iq_alu;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    flush_i;
    logic                    enq_valid_i;
    logic                    enq_ready_o;
    logic [1:0]              enq_choose_i;
    logic [1:0][1:0][5:0]    enq_src_preg_i;
    logic [1:0][1:0][31:0]   enq_src_data_i;
    logic [1:0][1:0]         enq_src_valid_i;
    logic [1:0][127:0]       enq_payload_i;
    logic [1:0]              cdb_valid_i;
    logic [1:0][5:0]         cdb_preg_i;
    logic [1:0][31:0]        cdb_data_i;
    logic                    issue_valid_o;
    logic                    issue_ready_i;
    logic [1:0][31:0]        issue_src_data_o;
    logic [127:0]            issue_payload_o;
    logic [3:0]              count_o;

    int n_cmp = 0;
    int n_err = 0;

    iq_alu #(.DEPTH(8), .PREG_W(6), .PAYLOAD_W(128)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush_i),
        .enq_valid_i      (enq_valid_i),
        .enq_ready_o      (enq_ready_o),
        .enq_choose_i     (enq_choose_i),
        .enq_src_preg_i   (enq_src_preg_i),
        .enq_src_data_i   (enq_src_data_i),
        .enq_src_valid_i  (enq_src_valid_i),
        .enq_payload_i    (enq_payload_i),
        .cdb_valid_i      (cdb_valid_i),
        .cdb_preg_i       (cdb_preg_i),
        .cdb_data_i       (cdb_data_i),
        .issue_valid_o    (issue_valid_o),
        .issue_ready_i    (issue_ready_i),
        .issue_src_data_o (issue_src_data_o),
        .issue_payload_o  (issue_payload_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, got running, need done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        flush_i         = 1'b0;
        enq_valid_i     = 1'b0;
        enq_choose_i    = 2'b00;
        enq_src_preg_i  = '0;
        enq_src_data_i  = '0;
        enq_src_valid_i = '0;
        enq_payload_i   = '0;
        cdb_valid_i     = 2'b00;
        cdb_preg_i      = '0;
        cdb_data_i      = '0;
    endtask

    task automatic set_slot(input int k,
                            input logic [5:0] p0, input logic [31:0] d0, input logic v0,
                            input logic [5:0] p1, input logic [31:0] d1, input logic v1,
                            input logic [127:0] pl);
        enq_src_preg_i[k][0]  = p0;
        enq_src_data_i[k][0]  = d0;
        enq_src_valid_i[k][0] = v0;
        enq_src_preg_i[k][1]  = p1;
        enq_src_data_i[k][1]  = d1;
        enq_src_valid_i[k][1] = v1;
        enq_payload_i[k]      = pl;
    endtask

    initial begin
        idle_in();
        issue_ready_i = 1'b0;
        rst_n         = 1'b0;

        // 1: reset then idle
        step();
        chk("rst_enq_ready", enq_ready_o, 0);
        chk("rst_issue_valid", issue_valid_o, 0);
        chk("rst_count", count_o, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("idle_enq_ready", enq_ready_o, 1);
        chk("idle_issue_valid", issue_valid_o, 0);
        chk("idle_count", count_o, 0);

        // 2: ready on dispatch
        issue_ready_i = 1'b1;
        set_slot(0, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 1'b1, 128'hA5A5);
        enq_valid_i = 1'b1; enq_choose_i = 2'b01;
        #1;
        chk("t2_no_issue_same_cycle", issue_valid_o, 0);
        step();
        idle_in();
        #1;
        chk("t2_issue_valid", issue_valid_o, 1);
        chk("t2_issue_data", issue_src_data_o, 64'h00000022_00000011);
        chk("t2_payload", issue_payload_o, 128'hA5A5);
        chk("t2_count1", count_o, 1);
        step();
        chk("t2_count0", count_o, 0);
        chk("t2_drained", issue_valid_o, 0);

        // choose=10 keeps slot 1 only; choose=00 fires without effect
        issue_ready_i = 1'b0;
        set_slot(0, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1, 128'hA0);
        set_slot(1, 6'd3, 32'h3, 1'b1, 6'd4, 32'h4, 1'b1, 128'hB0);
        enq_valid_i = 1'b1; enq_choose_i = 2'b10;
        step();
        enq_choose_i = 2'b00;
        #1;
        chk("c10_count", count_o, 1);
        chk("c10_payload", issue_payload_o, 128'hB0);
        step();
        idle_in();
        #1;
        chk("c00_count", count_o, 1);
        issue_ready_i = 1'b1;
        step();
        chk("c10_drain", count_o, 0);

        // 3: wakeup ordering; both CDB ports hit preg 5, port 0 wins
        set_slot(0, 6'd1, 32'h1, 1'b1, 6'd5, 32'h0, 1'b0, 128'hA);
        enq_valid_i = 1'b1; enq_choose_i = 2'b01;
        step();
        idle_in();
        #1;
        chk("t3_A_waits", issue_valid_o, 0);
        set_slot(0, 6'd1, 32'h3, 1'b1, 6'd2, 32'h4, 1'b1, 128'hB);
        enq_valid_i = 1'b1; enq_choose_i = 2'b01;
        step();
        idle_in();
        cdb_valid_i = 2'b11;
        cdb_preg_i[0] = 6'd5; cdb_data_i[0] = 32'hDEAD;
        cdb_preg_i[1] = 6'd5; cdb_data_i[1] = 32'hBEEF;
        #1;
        chk("t3_B_first", issue_payload_o, 128'hB);
        chk("t3_count2", count_o, 2);
        step();
        idle_in();
        #1;
        chk("t3_A_valid", issue_valid_o, 1);
        chk("t3_A_payload", issue_payload_o, 128'hA);
        chk("t3_A_data", issue_src_data_o, 64'h0000DEAD_00000001);
        step();
        chk("t3_count0", count_o, 0);

        // 4: same-cycle bypass from CDB port 1
        set_slot(0, 6'd9, 32'h0, 1'b0, 6'd2, 32'h77, 1'b1, 128'hC);
        enq_valid_i = 1'b1; enq_choose_i = 2'b01;
        cdb_valid_i = 2'b10; cdb_preg_i[1] = 6'd9; cdb_data_i[1] = 32'h55;
        step();
        idle_in();
        #1;
        chk("t4_valid", issue_valid_o, 1);
        chk("t4_data", issue_src_data_o, 64'h00000077_00000055);
        step();
        chk("t4_count0", count_o, 0);

        // 5: fill to full under backpressure, then drain in order
        issue_ready_i = 1'b0;
        for (int r = 0; r < 4; r++) begin
            set_slot(0, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1, 128'(2*r+1));
            set_slot(1, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1, 128'(2*r+2));
            enq_valid_i = 1'b1; enq_choose_i = 2'b11;
            #1;
            chk("t5_fill_ready", enq_ready_o, 1);
            step();
            idle_in();
            #1;
            chk("t5_fill_count", count_o, 128'(2*r+2));
        end
        chk("t5_full_ready", enq_ready_o, 0);
        chk("t5_hold_valid", issue_valid_o, 1);
        chk("t5_hold_payload", issue_payload_o, 128'd1);
        set_slot(0, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1, 128'hEE);
        enq_valid_i = 1'b1; enq_choose_i = 2'b11;
        step();
        idle_in();
        #1;
        chk("t5_no_overflow", count_o, 8);
        issue_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t5_drain_payload", issue_payload_o, 128'(i+1));
            chk("t5_drain_count", count_o, 128'(8-i));
            chk("t5_drain_ready", enq_ready_o, 128'((8-i) <= 6));
            step();
        end
        chk("t5_empty", count_o, 0);

        // 6: flush with 5 entries, enqueue, issue and wakeup all in the same cycle
        issue_ready_i = 1'b0;
        for (int r = 0; r < 3; r++) begin
            set_slot(0, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1, 128'(8'h61 + 2*r));
            set_slot(1, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1, 128'(8'h62 + 2*r));
            enq_valid_i = 1'b1; enq_choose_i = (r == 2) ? 2'b01 : 2'b11;
            step();
            idle_in();
        end
        #1;
        chk("t6_count5", count_o, 5);
        chk("t6_head", issue_payload_o, 128'h61);
        flush_i = 1'b1; issue_ready_i = 1'b1;
        enq_valid_i = 1'b1; enq_choose_i = 2'b11;
        cdb_valid_i = 2'b01; cdb_preg_i[0] = 6'd12; cdb_data_i[0] = 32'hC0;
        #1;
        chk("t6_flush_issue", issue_valid_o, 0);
        chk("t6_flush_enq_ready", enq_ready_o, 0);
        chk("t6_flush_payload", issue_payload_o, 0);
        step();
        idle_in();
        #1;
        chk("t6_count0", count_o, 0);
        set_slot(0, 6'd12, 32'h0, 1'b0, 6'd2, 32'h2, 1'b1, 128'h70);
        enq_valid_i = 1'b1; enq_choose_i = 2'b01;
        step();
        idle_in();
        #1;
        chk("t6_stale_wakeup", issue_valid_o, 0);
        cdb_valid_i = 2'b10; cdb_preg_i[1] = 6'd12; cdb_data_i[1] = 32'hC1;
        #1;
        chk("t6_no_select_bypass", issue_valid_o, 0);
        step();
        idle_in();
        set_slot(0, 6'd1, 32'h5, 1'b1, 6'd2, 32'h6, 1'b1, 128'h71);
        enq_valid_i = 1'b1; enq_choose_i = 2'b01;
        #1;
        chk("t6_woken_valid", issue_valid_o, 1);
        chk("t6_woken_data", issue_src_data_o, 64'h00000002_000000C1);
        chk("t6_woken_payload", issue_payload_o, 128'h70);
        step();
        idle_in();
        #1;
        chk("t6_iss_enq_count", count_o, 1);
        chk("t6_next_payload", issue_payload_o, 128'h71);
        step();
        chk("t6_final_count", count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iq_alu.md
Name: iq_alu

Overview:
- One ALU issue queue, directly downstream of the dispatch stage. Two instances are built, one per ALU queue (even / odd destination preg).
- Accepts up to two dispatched instructions per cycle, selected by a per-slot choose mask.
- Holds each instruction until both source operands are valid, capturing them from CDB wakeups.
- Issues the oldest ready instruction, one per cycle, to its ALU through a valid/ready handshake.

Parameters:
- DEPTH, 8: number of queue entries (≥4).
- PREG_W, 6: physical register index width.
- PAYLOAD_W, 128: opaque per-instruction payload (decode info: pc, imm, op, wreg_id, etc.); carried unchanged.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  pipeline flush.
- enq_valid_i  in  1  dispatch offers a packet.
- enq_ready_o  out  1  queue can accept a full packet.
- enq_choose_i  in  2  slot k of the packet belongs to this queue.
- enq_src_preg_i  in  2x2xPREG_W  source pregs; index [slot][operand].
- enq_src_data_i  in  2x2x32  source data already known.
- enq_src_valid_i  in  2x2  source data valid.
- enq_payload_i  in  2xPAYLOAD_W  per-slot payload.
- cdb_valid_i  in  2  wakeup valid, two ports.
- cdb_preg_i  in  2xPREG_W  wakeup preg.
- cdb_data_i  in  2x32  wakeup data.
- issue_valid_o  out  1  an entry is issuing.
- issue_ready_i  in  1  ALU accepts.
- issue_src_data_o  out  2x32  operand 0 and operand 1 data.
- issue_payload_o  out  PAYLOAD_W  payload of the issuing entry.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset: rst_n is synchronous and active-low, sampled on the rising edge of clk. While rst_n is low, all entry valids clear and count is 0. enq_ready_o and issue_valid_o are 0 whenever rst_n is low; count_o reads 0 after the first reset edge.
- Storage: compacting age-ordered array; entry 0 is the oldest. Per entry: valid, src_preg[2], src_data[2], src_rdy[2], payload.
- enq_ready_o = rst_n & ~flush_i & (DEPTH − count ≥ 2).
  - Computed from current count only; it does not credit a same-cycle issue.
  - It does not depend on enq_valid_i or enq_choose_i.
- Enqueue fires when enq_valid_i & enq_ready_o.
  - Chosen slots are appended in order, slot 0 before slot 1, behind all surviving entries.
  - Unchosen slots are dropped.
  - A choose mask of 00 fires without changing state.
- Wakeup, resident entries: for each waiting operand, if cdb_valid_i[p] and cdb_preg_i[p] == src_preg, capture cdb_data_i[p] and set src_rdy at the next edge.
  - Port 0 has priority if both ports match.
  - cdb_preg 0 never matches.
- Wakeup, same-cycle bypass for enqueue: an incoming operand with enq_src_valid=0 that matches the CDB in its enqueue cycle is stored ready with the CDB data. An operand with enq_src_valid=1 keeps enq_src_data.
- Select (combinational from registered state only):
  - Chooses the lowest-index entry with valid & src_rdy[0] & src_rdy[1].
  - issue_valid_o = any such entry & rst_n & ~flush_i.
  - issue_src_data_o and issue_payload_o come from that entry; they are 0 when issue_valid_o=0.
  - The select does not bypass the CDB, so an operand woken at edge N makes its entry issuable in cycle N+1.
  - A newly enqueued entry is issuable no earlier than the cycle after its enqueue.
- Issue fires when issue_valid_o & issue_ready_i. The issued entry is removed at the edge and younger entries shift down by one.
- If issue_ready_i=0, the output is held. The selection may change only when an older entry becomes ready.
- Simultaneous issue and enqueue: removal happens first, then new entries append after the compacted survivors. The count update is count − issued + enqueued.
- Flush: at the edge where flush_i=1, all entries are invalidated and count becomes 0. Flush dominates enqueue, issue and wakeup in that cycle.
- Full: when count > DEPTH−2, enq_ready_o=0, while issue continues. The queue never overflows.
- Payload is never modified.

Test Plan:
1. Reset then idle: hold rst_n=0 for 2 cycles, then release with no stimulus → enq_ready_o=1, issue_valid_o=0, count_o=0.
2. Ready-on-dispatch: enqueue choose=01 with both sources valid (data 0x11, 0x22), issue_ready_i=1 → issue_valid_o=1 the next cycle with data {0x22,0x11} and the matching payload; count goes 1→0.
3. Wakeup ordering: enqueue A (src1 preg 5 not ready) then B (both sources ready) in a later cycle; pulse CDB preg 5 data 0xDEAD at cycle t → B issues first; A issues at t+1 with operand 1 = 0xDEAD.
4. Same-cycle bypass: enqueue with src0 preg 9 not ready while cdb_preg_i[1]=9, data 0x55 → the entry issues the next cycle with operand 0 = 0x55.
5. Full/backpressure: DEPTH=8, issue_ready_i=0, enqueue choose=11 four times → count_o=8 and enq_ready_o=0 from count 7 onward. Raise issue_ready_i=1 → entries drain in enqueue order, one per cycle; enq_ready_o returns to 1 at count 6.
6. Flush mid-operation: 5 entries resident, assert flush_i together with an enqueue and issue_ready_i=1 → no issue fire and no enqueue that cycle; count_o=0 the next cycle; a wakeup in the flush cycle has no effect.
